// File: rtl/tone_synth_pkg.sv
// Shared definitions for the tone synthesizer.
//   NOTE_W     : width of one voice's note code
//   wave_e     : per-voice waveform selection
//   PHASE_INC  : 16-bit phase increments for C4 + n-1 semitones at 44.1 kHz
//   scaled_inc : PHASE_INC entry rescaled to an arbitrary accumulator width (<= 32 bits)
package tone_synth_pkg;

  localparam int unsigned NOTE_W = 5;

  typedef enum logic [1:0] {
    WaveSquare = 2'd0,
    WaveSaw    = 2'd1,
    WaveTri    = 2'd2,
    WaveRsvd   = 2'd3
  } wave_e;

  // round(2^16 * 261.63 * 2^((n-1)/12) / 44100); entry 0 is the rest code.
  localparam logic [15:0] PHASE_INC [32] = '{
    16'd0,    16'd389,  16'd412,  16'd436,  16'd462,  16'd490,  16'd519,  16'd550,
    16'd583,  16'd617,  16'd654,  16'd693,  16'd734,  16'd778,  16'd824,  16'd873,
    16'd925,  16'd980,  16'd1038, 16'd1100, 16'd1165, 16'd1234, 16'd1308, 16'd1386,
    16'd1468, 16'd1555, 16'd1648, 16'd1746, 16'd1849, 16'd1959, 16'd2076, 16'd2199
  };

  // The table is defined for a 16-bit accumulator; shift it to other widths.
  function automatic logic [31:0] scaled_inc(input logic [NOTE_W-1:0] n,
                                             input int unsigned phase_w);
    logic [31:0] base;
    base = 32'(PHASE_INC[n]);
    if (phase_w >= 16) return base << (phase_w - 16);
    else               return base >> (16 - phase_w);
  endfunction

endpackage

// File: rtl/tone_voice.sv
// One tone voice: phase accumulator plus waveform shaper.
//   clk, rst_n : clock, async active-low reset
//   tick       : sample-period strobe; phase advances on this edge
//   note       : latched note code (0 = rest)
//   wave       : latched waveform
//   sample     : unsigned voice sample derived from the current phase
module tone_voice
  import tone_synth_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 9,
  parameter int unsigned PHASE_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [NOTE_W-1:0]   note,
  input  wave_e               wave,
  output logic [SAMPLE_W-1:0] sample
);

  logic [PHASE_W-1:0]  phase_q, phase_d, inc;
  logic [SAMPLE_W-1:0] s, tri_v;

  assign inc = PHASE_W'(scaled_inc(note, PHASE_W));

  // Rest forces phase to 0; nonzero note changes keep the running phase.
  always_comb begin
    phase_d = phase_q;
    if (tick) begin
      phase_d = (note == '0) ? '0 : phase_q + inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase_q <= '0;
    else        phase_q <= phase_d;
  end

  assign s     = phase_q[PHASE_W-1 -: SAMPLE_W];
  assign tri_v = {s[SAMPLE_W-2:0], 1'b0};

  always_comb begin
    sample = '0;
    if (note != '0) begin
      case (wave)
        WaveSquare: sample = {SAMPLE_W{s[SAMPLE_W-1]}};
        WaveSaw:    sample = s;
        WaveTri:    sample = s[SAMPLE_W-1] ? ~tri_v : tri_v;
        default:    sample = '0;
      endcase
    end
  end

endmodule

// File: rtl/tone_synth.sv
// Multi-voice tone synthesizer: tick divider, latched voice settings, VOICES
// tone_voice instances and an averaging mixer.
//   clk, rst_n   : clock, async active-low reset
//   note         : VOICES x 5-bit note codes (voice v at [5v+4:5v])
//   wave_sel     : VOICES x 2-bit waveform selects
//   note_load    : strobe latching note and wave_sel for all voices
//   value        : mixed unsigned sample, held between updates
//   sample_valid : one-cycle pulse when value is refreshed
module tone_synth
  import tone_synth_pkg::*;
#(
  parameter int unsigned VOICES   = 2,
  parameter int unsigned SAMPLE_W = 9,
  parameter int unsigned PHASE_W  = 16,
  parameter int unsigned TICK_DIV = 1134
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [VOICES*NOTE_W-1:0]   note,
  input  logic [VOICES*2-1:0]        wave_sel,
  input  logic                       note_load,
  output logic [SAMPLE_W-1:0]        value,
  output logic                       sample_valid
);

  localparam int unsigned LOG_V = $clog2(VOICES);
  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam int unsigned SUM_W = SAMPLE_W + LOG_V;

  logic [CNT_W-1:0]         cnt_q;
  logic                     tick, tick_q;
  logic [VOICES*NOTE_W-1:0] note_q;
  logic [VOICES*2-1:0]      wave_q;
  logic [SAMPLE_W-1:0]      samples [VOICES];
  logic [SUM_W-1:0]         sum;
  logic [SAMPLE_W-1:0]      mix;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      note_q <= '0;
      wave_q <= '0;
    end else begin
      cnt_q  <= tick ? '0 : cnt_q + CNT_W'(1);
      tick_q <= tick;
      // A load on the tick edge is seen by the voices only from the next tick.
      if (note_load) begin
        note_q <= note;
        wave_q <= wave_sel;
      end
    end
  end

  for (genvar v = 0; v < VOICES; v++) begin : g_voice
    tone_voice #(
      .SAMPLE_W (SAMPLE_W),
      .PHASE_W  (PHASE_W)
    ) u_voice (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .note   (note_q[v*NOTE_W +: NOTE_W]),
      .wave   (wave_e'(wave_q[2*v +: 2])),
      .sample (samples[v])
    );
  end

  // Sum carries LOG_V extra bits so the average never overflows.
  always_comb begin
    sum = '0;
    for (int unsigned v = 0; v < VOICES; v++) begin
      sum = sum + SUM_W'(samples[v]);
    end
    mix = SAMPLE_W'(sum >> LOG_V);
  end

  // One cycle after the tick edge the phases already hold their new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= tick_q;
      if (tick_q) value <= mix;
    end
  end

endmodule

// File: doc/tone_synth.md
TONE_SYNTH -- requirements
Module: tone_synth

Interface
REQ-001 Parameter VOICES, default 2, number of independent tone voices; SHALL be a power of two, 1..8.
REQ-002 Parameter SAMPLE_W, default 9, output sample width in bits.
REQ-003 Parameter PHASE_W, default 16, phase-accumulator width; SHALL be >= SAMPLE_W.
REQ-004 Parameter TICK_DIV, default 1134, clk cycles per sample period (50 MHz / 44.1 kHz); SHALL be >= 3.
REQ-005 clk  in  1  single system clock; all state SHALL be rising-edge clocked.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 note  in  VOICES*5  per-voice note code, voice v at bits [5v+4:5v]; 0 = rest, 1..31 = semitones upward from C4 (261.63 Hz).
REQ-008 wave_sel  in  VOICES*2  per-voice waveform: 0 square, 1 sawtooth, 2 triangle, 3 reserved (silent).
REQ-009 note_load  in  1  single-cycle strobe; latches all note and wave_sel fields together.
REQ-010 value  out  SAMPLE_W  unsigned mixed sample, held between updates.
REQ-011 sample_valid  out  1  one-cycle pulse marking a new value.

Function
- REQ-012 Tick counter: counts 0..TICK_DIV-1 and wraps; tick is asserted in the cycle where count == TICK_DIV-1.
- REQ-013 Latched note/wave registers: update on the edge where note_load=1; they have no other effect.
- REQ-014 Phase update: on each tick edge, every voice with latched note != 0 SHALL do phase <= phase + PHASE_INC[note] mod 2^PHASE_W (wrap silently).
- REQ-015 Rest: a voice with latched note == 0 SHALL force phase to 0 on the tick edge and contribute 0.
- REQ-016 note_load coinciding with tick: the tick SHALL use the pre-load latched values; new values apply from the next tick.
- REQ-017 Note changes between two nonzero codes SHALL be phase-continuous (no phase reset).
- REQ-018 Voice sample s = phase[PHASE_W-1 -: SAMPLE_W]. Square: 2^SAMPLE_W-1 when phase MSB=1, else 0. Sawtooth: s. Triangle: {s[SAMPLE_W-2:0],0} when MSB=0, else bitwise-inverse of that. Reserved: 0.
- REQ-019 Mixer: value = (sum of VOICES voice samples) >> log2(VOICES); the sum SHALL be carried at SAMPLE_W+log2(VOICES) bits, so no overflow or saturation.
- REQ-020 Latency: value and sample_valid SHALL be registered on the edge one cycle after the tick edge, using post-update phases; sample_valid is high exactly one cycle per TICK_DIV cycles.
- REQ-021 value SHALL hold its last result until the next sample_valid.

Reset
- REQ-022 While rst_n=0, these SHALL be cleared asynchronously: tick counter 0, all phases 0, latched notes 0 (rest), latched wave_sel 0, value 0, sample_valid 0.
- REQ-023 After rst_n deasserts, the first sample_valid SHALL occur TICK_DIV+1 cycles after the first active edge.
- REQ-024 Reset asserted mid-period SHALL abandon the period with no partial sample_valid.

Structure
- REQ-025 Package tone_synth_pkg SHALL hold the 32-entry PHASE_INC table, the waveform enum and the NOTE_W=5 constant.
- REQ-026 PHASE_INC[n] = round(2^16 * 261.63 * 2^((n-1)/12) / 44100), with entry 0 = 0, scaled for PHASE_W.
- REQ-027 Sub-module tone_voice SHALL implement one voice (phase accumulator plus waveform shaper), instantiated VOICES times by generate; the tick counter and mixer stay in tone_synth.

Verification
- REQ-028 Reset: assert rst_n=0 mid-period -> value=0 and sample_valid=0 immediately; after release, first sample_valid at cycle TICK_DIV+1.
- REQ-029 TICK_DIV=4, all voices rest -> sample_valid every 4th cycle, value stays 0.
- REQ-030 VOICES=2, voice0 sawtooth note 10 (inc 654), voice1 rest -> successive values 2, 5, 7, ... (phase[15:7]>>1); phase wraps after tick 101 with no glitch.
- REQ-031 Both voices square, note 10 -> value 511 while the phase MSB is set, else 0; period about 100 ticks.
- REQ-032 note_load on the tick cycle, changing 10 to 22 -> that tick still adds 654; the next tick adds PHASE_INC[22]; no phase reset.
- REQ-033 wave_sel=3 on a sounding voice -> zero contribution, while its phase keeps advancing (checked by switching back to sawtooth).
